// File: rtl/tlc_event_log.sv
// Traffic-light event logger: captures light/ped state changes into a first-word-fall-through FIFO for host readout.
// Optional feature: define TLC_EVT_TIMESTAMP_EN to stamp each event with a 16-bit tick count in bits [31:16].
module tlc_event_log #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             okClk,
    input  logic             rst,
    input  logic [1:0]       light_ns,
    input  logic [1:0]       light_ew,
    input  logic [3:0]       ped_sigs,
    input  logic             tick,
    input  logic             pop_req,
    input  logic             clr_ovf,
    output logic [31:0]      evt_data,
    output logic             evt_valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]       r_snap;
    logic             r_snap_vld;
    logic [7:0]       r_last;
    logic             r_last_vld;
    logic [7:0]       r_seq;
    logic             r_pop_d;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic [31:0]      r_mem [DEPTH];

    logic [15:0]      w_ts;
    logic [31:0]      w_word;
    logic             w_evt;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;

`ifdef TLC_EVT_TIMESTAMP_EN
    logic             r_tick_d;
    logic [15:0]      r_ts;

    always_ff @(posedge okClk) begin
        if (rst) begin
            r_tick_d <= 1'b0;
            r_ts     <= 16'h0000;
        end else begin
            r_tick_d <= tick;
            if (tick && !r_tick_d) begin
                r_ts <= r_ts + 16'd1;
            end
        end
    end

    assign w_ts = r_ts;
`else
    logic w_unused_tick;

    assign w_unused_tick = tick;
    assign w_ts          = 16'h0000;
`endif

    // An invalid last-logged value forces the first snapshot after reset to be logged as a baseline.
    assign w_evt   = r_snap_vld && (!r_last_vld || (r_snap != r_last));
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = pop_req && !r_pop_d && !w_empty;
    assign w_push  = w_evt && (!w_full || w_pop);
    assign w_word  = {w_ts, r_seq, r_snap};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge okClk) begin
        if (rst) begin
            r_snap     <= 8'h00;
            r_snap_vld <= 1'b0;
            r_last     <= 8'h00;
            r_last_vld <= 1'b0;
            r_seq      <= 8'h00;
            r_pop_d    <= 1'b0;
        end else begin
            r_snap     <= {light_ns, light_ew, ped_sigs};
            r_snap_vld <= 1'b1;
            r_pop_d    <= pop_req;
            if (w_evt) begin
                r_last     <= r_snap;
                r_last_vld <= 1'b1;
                r_seq      <= r_seq + 8'd1;
            end
        end
    end

    always_ff @(posedge okClk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle wins over a clear request.
            if (w_evt && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // NOTE: storage has no reset; the pointers and count define which words are meaningful.
    always_ff @(posedge okClk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    assign evt_data  = w_empty ? 32'h0000_0000 : r_mem[r_rd_ptr];
    assign evt_valid = !w_empty;
    assign count     = r_count;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_tlc_event_log.sv
// Directed bench for tlc_event_log: a scoreboard queue mirrors the FIFO contents and flags.
module tb_tlc_event_log;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             okClk = 1'b0;
    logic             rst;
    logic [1:0]       light_ns;
    logic [1:0]       light_ew;
    logic [3:0]       ped_sigs;
    logic             tick;
    logic             pop_req;
    logic             clr_ovf;
    logic [31:0]      evt_data;
    logic             evt_valid;
    logic [CNT_W-1:0] count;
    logic             overflow;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q [$];
    logic [7:0]  m_seq;
    logic [15:0] m_ts;
    logic        m_ovf;

    tlc_event_log #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .okClk     (okClk),
        .rst       (rst),
        .light_ns  (light_ns),
        .light_ew  (light_ew),
        .ped_sigs  (ped_sigs),
        .tick      (tick),
        .pop_req   (pop_req),
        .clr_ovf   (clr_ovf),
        .evt_data  (evt_data),
        .evt_valid (evt_valid),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 okClk = ~okClk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(sb_q.size()));
        chk({tag, ".valid"}, 32'(evt_valid), 32'(sb_q.size() != 0));
        chk({tag, ".data"}, evt_data, (sb_q.size() != 0) ? sb_q[0] : 32'h0);
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge okClk);
    endtask

    function automatic logic [15:0] ts_field();
`ifdef TLC_EVT_TIMESTAMP_EN
        return m_ts;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic drive_s(input logic [7:0] v);
        {light_ns, light_ew, ped_sigs} = v;
    endtask

    task automatic log_evt(input logic [7:0] v);
        if (sb_q.size() < DEPTH) sb_q.push_back({ts_field(), m_seq, v});
        else m_ovf = 1'b1;
        m_seq++;
    endtask

    task automatic change_s(input logic [7:0] v);
        drive_s(v);
        log_evt(v);
        step(3);
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step(2);
        tick = 1'b0;
        step(2);
        m_ts++;
    endtask

    task automatic pop_pulse();
        pop_req = 1'b1;
        step(1);
        pop_req = 1'b0;
        step(2);
        if (sb_q.size() != 0) void'(sb_q.pop_front());
    endtask

    task automatic drain(input string tag);
        while (sb_q.size() != 0) begin
            chk_state(tag);
            pop_pulse();
        end
        chk_state({tag, ".empty"});
    endtask

    initial begin
        rst      = 1'b1;
        tick     = 1'b0;
        pop_req  = 1'b0;
        clr_ovf  = 1'b0;
        m_seq    = 8'h00;
        m_ts     = 16'h0000;
        m_ovf    = 1'b0;
        drive_s(8'h55);
        step(3);
        chk_state("reset");

        // Baseline event two edges after reset release.
        rst = 1'b0;
        step(1);
        chk("latency.count1", 32'(count), 32'd0);
        log_evt(8'h55);
        step(1);
        chk_state("baseline");
        chk("baseline.word", evt_data, 32'h0000_0055);

        repeat (3) tick_pulse();
        change_s(8'h95);
        chk_state("second");
        pop_pulse();
        chk_state("after_pop");
`ifdef TLC_EVT_TIMESTAMP_EN
        chk("ts_word", evt_data, 32'h0003_0195);
`else
        chk("ts_word", evt_data, 32'h0000_0195);
`endif
        drain("drain1");
        pop_pulse();
        chk_state("pop_empty");

        // Held pop level must pop exactly once.
        repeat (2) tick_pulse();
        change_s(8'hA1);
        change_s(8'hA2);
        change_s(8'hA3);
        chk_state("three");
        pop_req = 1'b1;
        step(10);
        pop_req = 1'b0;
        step(2);
        void'(sb_q.pop_front());
        chk_state("held_pop");
        drain("drain2");

        for (int i = 0; i < 17; i++) change_s(8'h10 + 8'(i));
        chk_state("overflow");

        // Drop coinciding with clear keeps the flag set.
        clr_ovf = 1'b1;
        step(1);
        m_ovf = 1'b0;
        chk_state("clr_ovf");
        drive_s(8'h30);
        log_evt(8'h30);
        step(2);
        clr_ovf = 1'b0;
        step(1);
        chk_state("drop_vs_clr");
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        step(1);
        m_ovf = 1'b0;
        chk_state("clr_again");

        // Push and pop on the same edge while full.
        drive_s(8'h31);
        step(1);
        pop_req = 1'b1;
        chk_state("simul.before");
        void'(sb_q.pop_front());
        log_evt(8'h31);
        step(1);
        pop_req = 1'b0;
        step(2);
        chk_state("simul.after");
        drain("drain3");

        // Reset mid-operation with a push and pop in flight.
        change_s(8'h41);
        change_s(8'h42);
        drive_s(8'h40);
        pop_req = 1'b1;
        rst     = 1'b1;
        step(2);
        sb_q.delete();
        m_seq = 8'h00;
        m_ts  = 16'h0000;
        m_ovf = 1'b0;
        chk_state("mid_reset");
        pop_req = 1'b0;
        step(1);
        rst = 1'b0;
        log_evt(8'h40);
        step(2);
        chk_state("rebaseline");
        chk("rebaseline.word", evt_data, 32'h0000_0040);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/tlc_event_log.md
TLC_EVENT_LOG -- requirements
Module: tlc_event_log

Interface
REQ-001 SHALL have parameter DEPTH, 16, FIFO depth in event words (power of two, 4..64).
REQ-002 SHALL have parameter CNT_W, 5, width of count output (equals log2(DEPTH)+1).
REQ-003 SHALL have port okClk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port light_ns  input  2  north-south light state from tlc.
REQ-006 SHALL have port light_ew  input  2  east-west light state from tlc.
REQ-007 SHALL have port ped_sigs  input  4  pedestrian signals from tlc.
REQ-008 SHALL have port tick  input  1  slow clock (clk_1hz) sampled as data; rising edge advances timestamp.
REQ-009 SHALL have port pop_req  input  1  level from host WireIn bit; rising edge pops one event.
REQ-010 SHALL have port clr_ovf  input  1  level-high clears overflow.
REQ-011 SHALL have port evt_data  output  32  head-of-FIFO event word for host WireOut.
REQ-012 SHALL have port evt_valid  output  1  high when FIFO non-empty.
REQ-013 SHALL have port count  output  CNT_W  number of stored events.
REQ-014 SHALL have port overflow  output  1  sticky flag: an event was dropped.

Function
REQ-015 SHALL register snapshot S={light_ns,light_ew,ped_sigs} every cycle; event raised when registered S differs from last-logged value L.
REQ-016 SHALL write event to FIFO on the edge after S is registered (2-cycle input-to-count latency) and update L to S.
REQ-017 SHALL format event word: [7:0]=S, [15:8]=8-bit sequence number, [31:16]=timestamp.
REQ-018 SHALL increment sequence number on every raised event, including dropped ones; wraps 255->0.
REQ-019 SHALL detect tick and pop_req rising edges via one-cycle-delayed registered copies; a level held high produces exactly one edge.
REQ-020 SHALL increment 16-bit timestamp per tick rising edge; wraps 65535->0.
REQ-021 SHALL present head word on evt_data combinationally from storage (first-word fall-through); evt_data=0 when empty.
REQ-022 SHALL, on pop edge with FIFO non-empty, advance head next cycle; pop when empty ignored, no state change.
REQ-023 SHALL, on event with FIFO full and no pop same cycle, drop event and set overflow.
REQ-024 SHALL, on simultaneous push and pop, perform both; count unchanged; when full, push accepted, no overflow.
REQ-025 SHALL clear overflow while clr_ovf high; a drop in the same cycle takes priority (overflow stays 1).
REQ-026 SHALL wrap read/write pointers modulo DEPTH; count ranges 0..DEPTH.

Reset
REQ-027 SHALL, while rst high, set count=0, evt_valid=0, evt_data=0, overflow=0, sequence=0, timestamp=0, pointers=0, edge registers=0.
REQ-028 SHALL treat L as invalid after reset so the first registered snapshot is always logged as a baseline event (seq 0).
REQ-029 SHALL discard all stored events on reset asserted mid-operation, including a push or pop in flight.

Configuration
REQ-030 SHALL, with TLC_EVT_TIMESTAMP_EN defined, build the timestamp counter and fill bits [31:16] as REQ-017.
REQ-031 SHALL, without TLC_EVT_TIMESTAMP_EN, omit the timestamp counter and tick edge logic; bits [31:16] tie to 0; tick unused.

Verification
REQ-032 Reset release, S=8'h55 held -> cycle 2: count=1, evt_data=32'h0000_0055, evt_valid=1.
REQ-033 S changes 8'h55->8'h95 after 3 tick edges (macro on) -> second event 32'h0003_0195 behind baseline; pop edge -> evt_data=32'h0003_0195, count=1.
REQ-034 17 distinct changes with no pops, DEPTH=16 -> count=16, overflow=1, 17th dropped; next logged event has seq gap of one.
REQ-035 FIFO full, change and pop edge same cycle -> count stays 16, overflow stays 0, new word at tail.
REQ-036 pop_req held high 10 cycles with 3 events stored -> exactly one pop, count=2; pop on empty FIFO -> count=0, no underflow.
REQ-037 Macro off, 5 tick edges then change -> evt_data[31:16]=16'h0000.
